// File: rtl/board_uart_pkg.sv
// Shared definitions for the board-state UART reporter: frame characters,
// frame length, frame FSM encoding and the cell-to-character mapping.
package board_uart_pkg;

  localparam logic [7:0] CH_X     = 8'h58;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_BAD   = 8'h23;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  localparam int FRAME_LEN = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_FINISH
  } frame_state_t;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] o;
    logic [2:0] status;
  } snapshot_t;

  // A cell claimed by both players is an illegal board, but it is still reported.
  function automatic logic [7:0] cell_char(input logic x_bit, input logic o_bit);
    logic [7:0] ch;
    case ({x_bit, o_bit})
      2'b10:   ch = CH_X;
      2'b01:   ch = CH_O;
      2'b11:   ch = CH_BAD;
      default: ch = CH_EMPTY;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/board_uart_tx_byte.sv
// 8N1 byte serializer. The start bit is driven in the same cycle start is
// seen, so a byte requested right after byte_done follows with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       byte_done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);

  logic          active;
  logic [TW-1:0] timer;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end   = (timer == TIMER_MAX);
  assign byte_done = active && bit_end && (bit_idx == 4'd9);

  // The start cycle itself is cycle 0 of the start bit, hence the timer preset of 1.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      active  <= 1'b0;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (start) begin
      active  <= 1'b1;
      timer   <= TW'(1);
      bit_idx <= '0;
      shreg   <= data;
    end else if (active) begin
      timer <= bit_end ? '0 : timer + 1'b1;
      if (bit_end) begin
        if (bit_idx == 4'd9) begin
          active  <= 1'b0;
          bit_idx <= '0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
        end
        if (bit_idx >= 4'd1 && bit_idx <= 4'd8) shreg <= {1'b0, shreg[7:1]};
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    if (start) begin
      tx = 1'b0;
    end else if (active) begin
      if (bit_idx == 4'd0)      tx = 1'b0;
      else if (bit_idx == 4'd9) tx = 1'b1;
      else                      tx = shreg[0];
    end
  end

endmodule

// File: rtl/board_uart_tx.sv
// Board-state reporter: snapshots the game state and sends it as a 12-byte
// ASCII frame ("cells, status, CR, LF") over a UART TX line.
module board_uart_tx
  import board_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter bit AUTO_SEND    = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [8:0] x_vec,
  input  logic [8:0] o_vec,
  input  logic [2:0] game_status,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  frame_state_t state, state_next;
  snapshot_t    live, snap, last_sent;
  logic [3:0]   byte_idx;
  logic [7:0]   byte_data;
  logic         pending, retrig, trigger;
  logic         ser_start, byte_done;

  assign live    = {x_vec, o_vec, game_status};
  assign trigger = send || retrig || (AUTO_SEND && (live != last_sent));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    ser_start  = 1'b0;
    case (state)
      ST_IDLE:   if (trigger) state_next = ST_LOAD;
      ST_LOAD: begin
        busy       = 1'b1;
        ser_start  = 1'b1;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (byte_done)
          state_next = (byte_idx == 4'(FRAME_LEN - 1)) ? ST_FINISH : ST_LOAD;
      end
      ST_FINISH: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // Snapshot, byte index, one-deep pending request and the last-sent copy.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      snap      <= '0;
      last_sent <= '0;
      byte_idx  <= '0;
      pending   <= 1'b0;
      retrig    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          retrig <= 1'b0;
          if (trigger) begin
            snap     <= live;
            byte_idx <= '0;
          end
        end
        ST_LOAD:  if (send) pending <= 1'b1;
        ST_SHIFT: begin
          if (send) pending <= 1'b1;
          if (byte_done && (byte_idx != 4'(FRAME_LEN - 1))) byte_idx <= byte_idx + 4'd1;
        end
        ST_FINISH: begin
          retrig    <= pending | send;
          pending   <= 1'b0;
          last_sent <= snap;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    byte_data = CH_LF;
    if (byte_idx < 4'd9)        byte_data = cell_char(snap.x[byte_idx], snap.o[byte_idx]);
    else if (byte_idx == 4'd9)  byte_data = CH_ZERO + {5'd0, snap.status};
    else if (byte_idx == 4'd10) byte_data = CH_CR;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk      (clk),
    .clr      (clr),
    .data     (byte_data),
    .start    (ser_start),
    .tx       (tx),
    .byte_done(byte_done)
  );

endmodule
